// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sprite_pkg
// Description : Shared screen constants and pixel type for the sprite layer.
// Revision    : 1.0 - initial release
// ============================================================================
package sprite_pkg;

    localparam int COORD_W  = 10;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } pixel_t;

endpackage : sprite_pkg
`default_nettype wire

// File: rtl/sprite_layer_renderer_if.sv
`default_nettype none
// ============================================================================
// Module      : sprite_layer_renderer_if
// Description : Sprite ROM and external palette bus (renderer = master).
// Revision    : 1.0 - initial release
// ============================================================================
interface sprite_layer_renderer_if #(
    parameter int ADDR_W = 12,
    parameter int IDX_W  = 3
);
    logic [ADDR_W-1:0] rom_address;
    logic [IDX_W-1:0]  rom_q;
    logic [IDX_W-1:0]  pal_idx;
    logic [3:0]        palette_red;
    logic [3:0]        palette_green;
    logic [3:0]        palette_blue;

    modport master (
        output rom_address, pal_idx,
        input  rom_q, palette_red, palette_green, palette_blue
    );

    modport slave (
        input  rom_address, pal_idx,
        output rom_q, palette_red, palette_green, palette_blue
    );
endinterface : sprite_layer_renderer_if
`default_nettype wire

// File: rtl/sprite_layer_renderer_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : sprite_addr_gen
// Description : Hit test, texel scaling/mirroring and registered ROM address.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_addr_gen
    import sprite_pkg::*;
#(
    parameter int SPR_W       = 32,
    parameter int SPR_H       = 32,
    parameter int SCALE_SHIFT = 1,
    parameter int FI_W        = 2,
    parameter int ADDR_W      = 12
) (
    input  logic               vga_clk,
    input  logic               Reset,
    input  logic [COORD_W-1:0] DrawX,
    input  logic [COORD_W-1:0] DrawY,
    input  logic               blank,
    input  logic [COORD_W-1:0] lx,
    input  logic [COORD_W-1:0] ly,
    input  logic               en,
    input  logic               mirror,
    input  logic [FI_W-1:0]    frame_sel,
    output logic [ADDR_W-1:0]  rom_address,
    output logic               hit,
    output logic               blank_q
);

    localparam logic [COORD_W-1:0] c_spr_w    = COORD_W'(SPR_W);
    localparam logic [COORD_W-1:0] c_spr_h    = COORD_W'(SPR_H);
    localparam logic [COORD_W-1:0] c_last_col = COORD_W'(SPR_W - 1);
    localparam logic [COORD_W-1:0] c_h_active = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] c_v_active = COORD_W'(V_ACTIVE);
    localparam logic [31:0]        c_frame_tx = 32'(SPR_W * SPR_H);
    localparam logic [31:0]        c_row_tx   = 32'(SPR_W);

    logic signed [COORD_W:0] w_dx;
    logic signed [COORD_W:0] w_dy;
    logic [COORD_W-1:0]      w_tx;
    logic [COORD_W-1:0]      w_ty;
    logic [COORD_W-1:0]      w_col;
    logic                    w_hit;
    logic [ADDR_W-1:0]       w_addr;

    // One extra bit makes left/above-the-sprite pixels negative, so a sprite
    // hanging off the right/bottom edge clips instead of wrapping around.
    assign w_dx  = $signed({1'b0, DrawX}) - $signed({1'b0, lx});
    assign w_dy  = $signed({1'b0, DrawY}) - $signed({1'b0, ly});
    assign w_tx  = w_dx[COORD_W-1:0] >> SCALE_SHIFT;
    assign w_ty  = w_dy[COORD_W-1:0] >> SCALE_SHIFT;
    assign w_col = mirror ? (c_last_col - w_tx) : w_tx;

    assign w_hit = en && blank && !w_dx[COORD_W] && !w_dy[COORD_W]
                && (w_tx < c_spr_w) && (w_ty < c_spr_h)
                && (DrawX < c_h_active) && (DrawY < c_v_active);

    assign w_addr = ADDR_W'(c_frame_tx * 32'(frame_sel) + c_row_tx * 32'(w_ty) + 32'(w_col));

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            rom_address <= '0;
            hit         <= 1'b0;
            blank_q     <= 1'b0;
        end else begin
            rom_address <= w_hit ? w_addr : '0;
            hit         <= w_hit;
            blank_q     <= blank;
        end
    end

endmodule : sprite_addr_gen
`default_nettype wire

// File: rtl/sprite_layer_renderer.sv
`default_nettype none
// ============================================================================
// Module      : sprite_layer_renderer
// Description : Scaled, animated, colour-keyed sprite layer with opaque flag.
//               Optional horizontal mirroring when SPRITE_MIRROR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_layer_renderer
    import sprite_pkg::*;
#(
    parameter int SPR_W       = 32,
    parameter int SPR_H       = 32,
    parameter int N_FRAMES    = 4,
    parameter int IDX_W       = 3,
    parameter int SCALE_SHIFT = 1,
    parameter int ROM_LAT     = 1,
    parameter int ANIM_PERIOD = 8,
    parameter int TRANSP_IDX  = 0,
    parameter int ADDR_W      = $clog2(SPR_W * SPR_H * N_FRAMES)
) (
    input  logic                        vga_clk,
    input  logic                        Reset,
    input  logic [COORD_W-1:0]          DrawX,
    input  logic [COORD_W-1:0]          DrawY,
    input  logic                        blank,
    input  logic [COORD_W-1:0]          pos_x,
    input  logic [COORD_W-1:0]          pos_y,
    input  logic                        enable,
    input  logic                        anim_run,
`ifdef SPRITE_MIRROR_EN
    input  logic                        mirror_x,
`endif
    sprite_layer_renderer_if.master     mem,
    output logic [3:0]                  red,
    output logic [3:0]                  green,
    output logic [3:0]                  blue,
    output logic                        opaque,
    output logic [$clog2(N_FRAMES)-1:0] frame_idx
);

    localparam int                  c_fi_w      = $clog2(N_FRAMES);
    localparam int                  c_anim_w    = $clog2(ANIM_PERIOD);
    localparam logic [c_anim_w-1:0] c_anim_last = c_anim_w'(ANIM_PERIOD - 1);
    localparam logic [c_fi_w-1:0]   c_frm_last  = c_fi_w'(N_FRAMES - 1);
    localparam logic [IDX_W-1:0]    c_transp    = IDX_W'(TRANSP_IDX);

    logic                 w_frame_start;
    logic [COORD_W-1:0]   r_lx, r_ly, w_lx, w_ly;
    logic                 r_en, w_en;
    logic                 w_mirror;
    logic [c_anim_w-1:0]  r_anim_cnt;
    logic [c_fi_w-1:0]    r_frame;
    logic                 r_hit_a, r_blank_a;
    logic                 w_hit_d, w_blank_d;
    logic                 w_opaque_nx;
    logic                 r_opaque;
    pixel_t               r_pix;

    assign w_frame_start = (DrawX == '0) && (DrawY == '0);

    // The frame-start pixel itself already uses the freshly sampled values.
    assign w_lx = w_frame_start ? pos_x  : r_lx;
    assign w_ly = w_frame_start ? pos_y  : r_ly;
    assign w_en = w_frame_start ? enable : r_en;

`ifdef SPRITE_MIRROR_EN
    logic r_mirror;
    always_ff @(posedge vga_clk) begin
        if (Reset)              r_mirror <= 1'b0;
        else if (w_frame_start) r_mirror <= mirror_x;
    end
    assign w_mirror = w_frame_start ? mirror_x : r_mirror;
`else
    assign w_mirror = 1'b0;
`endif

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            r_lx       <= '0;
            r_ly       <= '0;
            r_en       <= 1'b0;
            r_anim_cnt <= '0;
            r_frame    <= '0;
        end else if (w_frame_start) begin
            r_lx <= pos_x;
            r_ly <= pos_y;
            r_en <= enable;
            if (anim_run) begin
                if (r_anim_cnt == c_anim_last) begin
                    r_anim_cnt <= '0;
                    r_frame    <= (r_frame == c_frm_last) ? '0 : r_frame + 1'b1;
                end else begin
                    r_anim_cnt <= r_anim_cnt + 1'b1;
                end
            end
        end
    end

    sprite_addr_gen #(
        .SPR_W       (SPR_W),
        .SPR_H       (SPR_H),
        .SCALE_SHIFT (SCALE_SHIFT),
        .FI_W        (c_fi_w),
        .ADDR_W      (ADDR_W)
    ) u_addr_gen (
        .vga_clk     (vga_clk),
        .Reset       (Reset),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .lx          (w_lx),
        .ly          (w_ly),
        .en          (w_en),
        .mirror      (w_mirror),
        .frame_sel   (r_frame),
        .rom_address (mem.rom_address),
        .hit         (r_hit_a),
        .blank_q     (r_blank_a)
    );

    // The registered address is the first of the ROM_LAT cycles; the rest
    // of the read latency is matched here.
    generate
        if (ROM_LAT == 1) begin : g_lat_direct
            assign w_hit_d   = r_hit_a;
            assign w_blank_d = r_blank_a;
        end else begin : g_lat_pipe
            logic r_hit_pipe   [ROM_LAT-1];
            logic r_blank_pipe [ROM_LAT-1];
            always_ff @(posedge vga_clk) begin
                if (Reset) begin
                    for (int i = 0; i < ROM_LAT - 1; i++) begin
                        r_hit_pipe[i]   <= 1'b0;
                        r_blank_pipe[i] <= 1'b0;
                    end
                end else begin
                    r_hit_pipe[0]   <= r_hit_a;
                    r_blank_pipe[0] <= r_blank_a;
                    for (int i = 1; i < ROM_LAT - 1; i++) begin
                        r_hit_pipe[i]   <= r_hit_pipe[i-1];
                        r_blank_pipe[i] <= r_blank_pipe[i-1];
                    end
                end
            end
            assign w_hit_d   = r_hit_pipe[ROM_LAT-2];
            assign w_blank_d = r_blank_pipe[ROM_LAT-2];
        end
    endgenerate

    assign mem.pal_idx = mem.rom_q;
    assign w_opaque_nx = w_hit_d && w_blank_d && (mem.rom_q != c_transp);

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            r_opaque <= 1'b0;
            r_pix    <= '0;
        end else begin
            r_opaque <= w_opaque_nx;
            r_pix    <= w_opaque_nx ? pixel_t'({mem.palette_red, mem.palette_green, mem.palette_blue})
                                    : pixel_t'('0);
        end
    end

    assign red       = r_pix.r;
    assign green     = r_pix.g;
    assign blue      = r_pix.b;
    assign opaque    = r_opaque;
    assign frame_idx = r_frame;

endmodule : sprite_layer_renderer
`default_nettype wire

// File: tb/tb_sprite_layer_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_layer_renderer
// Description : Directed scoreboard bench for sprite_layer_renderer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_layer_renderer;

    localparam int ROM_LAT = 1;
    localparam int SHIFT   = 1;
    localparam int SW      = 32;
    localparam int SH      = 32;
    localparam int ANIM    = 8;
    localparam int NF      = 4;

    logic       vga_clk = 1'b0;
    logic       Reset   = 1'b1;
    logic [9:0] DrawX = '0, DrawY = '0, pos_x = '0, pos_y = '0;
    logic       blank = 1'b0, enable = 1'b0, anim_run = 1'b0;
    logic [3:0] red, green, blue;
    logic       opaque;
    logic [1:0] frame_idx;
`ifdef SPRITE_MIRROR_EN
    logic       mirror_x = 1'b0;
`endif

    sprite_layer_renderer_if #(.ADDR_W(12), .IDX_W(3)) mem_if ();

    logic [2:0] rom_mem [4096];
    assign mem_if.rom_q         = rom_mem[mem_if.rom_address];
    assign mem_if.palette_red   = {1'b0, mem_if.pal_idx};
    assign mem_if.palette_green = {mem_if.pal_idx, 1'b1};
    assign mem_if.palette_blue  = 4'd15 - {1'b0, mem_if.pal_idx};

    sprite_layer_renderer dut (
        .vga_clk   (vga_clk),
        .Reset     (Reset),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .blank     (blank),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .enable    (enable),
        .anim_run  (anim_run),
`ifdef SPRITE_MIRROR_EN
        .mirror_x  (mirror_x),
`endif
        .mem       (mem_if),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .opaque    (opaque),
        .frame_idx (frame_idx)
    );

    always #5 vga_clk = ~vga_clk;

    int cyc = 0;
    always @(posedge vga_clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [15:0] v;
        string       tag;
    } exp_t;

    exp_t q_addr[$];
    exp_t q_pix[$];
    exp_t ea, ep;
    int   n_checks = 0;
    int   n_errors = 0;

    int m_lx = 0, m_ly = 0, m_frame = 0, m_cnt = 0;
    bit m_en = 1'b0;

    function automatic logic [11:0] pal(logic [2:0] i);
        return {1'b0, i, i, 1'b1, 4'd15 - {1'b0, i}};
    endfunction

    task automatic check(string tag, logic [15:0] got, logic [15:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Drive one pixel and push the expected address and pixel results.
    task automatic drive(int x, int y, bit b, string tag);
        int dx, dy, addr;
        bit hit, op;
        logic [2:0] idx;
        @(posedge vga_clk); #1;
        DrawX = 10'(x); DrawY = 10'(y); blank = b;
        if (x == 0 && y == 0) begin
            m_lx = int'(pos_x); m_ly = int'(pos_y); m_en = enable;
        end
        dx   = x - m_lx;
        dy   = y - m_ly;
        hit  = m_en && b && dx >= 0 && dy >= 0 && (dx >> SHIFT) < SW && (dy >> SHIFT) < SH;
        addr = hit ? m_frame * SW * SH + (dy >> SHIFT) * SW + (dx >> SHIFT) : 0;
        idx  = rom_mem[addr];
        op   = hit && (idx != 3'd0);
        q_addr.push_back('{cyc + 1, 16'(addr), tag});
        q_pix.push_back('{cyc + 1 + ROM_LAT, {3'b0, op, op ? pal(idx) : 12'h000}, tag});
        if (x == 0 && y == 0 && anim_run) begin
            if (m_cnt == ANIM - 1) begin
                m_cnt   = 0;
                m_frame = (m_frame + 1) % NF;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic frame_start_gap();
        drive(0, 0, 1'b0, "fs");
        drive(1, 0, 1'b0, "fs_gap");
    endtask

    task automatic reset_window(string tag);
        repeat (3) begin
            @(posedge vga_clk); #1;
            check({tag, "_px"},   {3'b0, opaque, red, green, blue}, 16'h0000);
            check({tag, "_fidx"}, 16'(frame_idx), 16'h0000);
            check({tag, "_addr"}, 16'(mem_if.rom_address), 16'h0000);
        end
    endtask

    always @(negedge vga_clk) begin
        if (q_addr.size() > 0 && q_addr[0].due <= cyc) begin
            ea = q_addr.pop_front();
            n_checks++;
            assert (ea.due == cyc && 16'(mem_if.rom_address) === ea.v) else begin
                n_errors++;
                $error("FAIL %s rom_address got %0d exp %0d", ea.tag, mem_if.rom_address, ea.v);
            end
        end
        if (q_pix.size() > 0 && q_pix[0].due <= cyc) begin
            ep = q_pix.pop_front();
            n_checks++;
            assert (ep.due == cyc && {3'b0, opaque, red, green, blue} === ep.v) else begin
                n_errors++;
                $error("FAIL %s pixel got %0h exp %0h", ep.tag, {3'b0, opaque, red, green, blue}, ep.v);
            end
        end
    end

    initial begin
        for (int i = 0; i < 4096; i++) rom_mem[i] = 3'((i % 7) + 1);
        rom_mem[33] = 3'd0;
        rom_mem[34] = 3'd5;

        DrawX = 10'd101; DrawY = 10'd53; blank = 1'b1;
        reset_window("init_reset");
        Reset = 1'b0;

        // Basic placement, edges, blanking and colour key.
        pos_x = 10'd100; pos_y = 10'd50; enable = 1'b1;
        drive(0, 0, 1'b1, "fs0");
        drive(101, 53, 1'b1, "base_addr32");
        drive(99, 53, 1'b1, "left_out");
        drive(100, 50, 1'b1, "corner");
        drive(163, 53, 1'b1, "right_in");
        drive(164, 53, 1'b1, "right_out");
        drive(101, 113, 1'b1, "bottom_in");
        drive(101, 114, 1'b1, "bottom_out");
        drive(101, 53, 1'b0, "blanked");
        drive(102, 52, 1'b1, "transparent");
        drive(104, 52, 1'b1, "idx5");

        // Position change mid-frame takes effect only at next frame start.
        pos_x = 10'd200;
        drive(101, 53, 1'b1, "mid_old_pos");
        drive(201, 53, 1'b1, "mid_new_pos");
        drive(0, 0, 1'b1, "fs1");
        drive(201, 53, 1'b1, "next_new_pos");
        drive(101, 53, 1'b1, "next_old_pos");

        // Animation stepping, wrap and hold.
        pos_x = 10'd100;
        anim_run = 1'b1;
        repeat (8) frame_start_gap();
        check("anim_8", 16'(frame_idx), 16'd1);
        drive(101, 53, 1'b1, "frame1_tex");
        repeat (24) frame_start_gap();
        check("anim_32_wrap", 16'(frame_idx), 16'd0);
        repeat (8) frame_start_gap();
        anim_run = 1'b0;
        repeat (10) frame_start_gap();
        check("anim_hold", 16'(frame_idx), 16'd1);

        // Clipping near the bottom-right corner, then a disabled frame.
        pos_x = 10'd620; pos_y = 10'd470;
        drive(0, 0, 1'b1, "fs_edge");
        drive(639, 479, 1'b1, "clip_in");
        drive(2, 479, 1'b1, "no_wrap_x");
        drive(639, 2, 1'b1, "no_wrap_y");
        enable = 1'b0;
        drive(0, 0, 1'b1, "fs_disabled");
        drive(639, 479, 1'b1, "disabled");

        // Reset mid-line hides the sprite until an enabled frame start.
        enable = 1'b1; pos_x = 10'd100; pos_y = 10'd50;
        drive(0, 0, 1'b1, "fs_pre_reset");
        drive(101, 53, 1'b1, "pre_reset");
        @(posedge vga_clk); #1;
        Reset = 1'b1;
        q_addr.delete();
        q_pix.delete();
        m_lx = 0; m_ly = 0; m_en = 1'b0; m_frame = 0; m_cnt = 0;
        reset_window("mid_reset");
        Reset = 1'b0;
        drive(101, 53, 1'b1, "post_reset_hidden");
        drive(0, 0, 1'b1, "fs_post_reset");
        drive(101, 53, 1'b1, "post_reset_shown");

        repeat (ROM_LAT + 4) @(posedge vga_clk);
        n_checks++;
        assert (q_addr.size() == 0 && q_pix.size() == 0) else begin
            n_errors++;
            $error("FAIL drain pending got %0d exp 0", q_addr.size() + q_pix.size());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sprite_layer_renderer
`default_nettype wire

// File: doc/sprite_layer_renderer.md
Name: sprite_layer_renderer

Overview:
Parametrised successor to the full-screen sprite renderers. Draws one animated sprite, held in an external palette-indexed ROM, at a runtime position with power-of-two integer scaling and a transparency key. Outputs RGB plus an opaque flag so a downstream compositor can layer several instances. Single posedge clock and pipelined address generation (no dividers, no negedge ROM clock).

Parameters:
SPR_W, 32, sprite width in texels
SPR_H, 32, sprite height in texels
N_FRAMES, 4, animation frames stored back-to-back in ROM
IDX_W, 3, palette index width
SCALE_SHIFT, 1, on-screen texel size = 2**SCALE_SHIFT pixels
ROM_LAT, 1, ROM read latency in cycles (1..3)
ANIM_PERIOD, 8, video frames per animation step
TRANSP_IDX, 0, palette index treated as transparent
ADDR_W, $clog2(SPR_W*SPR_H*N_FRAMES), ROM address width

Ports:
vga_clk  in  1  pixel clock; all logic on posedge
Reset  in  1  synchronous, active-high
DrawX  in  10  current pixel column
DrawY  in  10  current pixel row
blank  in  1  1 = active video (same sense as existing renderers)
pos_x  in  10  sprite top-left X; sampled at frame start
pos_y  in  10  sprite top-left Y; sampled at frame start
enable  in  1  sprite visible; sampled at frame start
anim_run  in  1  1 = advance animation; 0 = hold frame
rom_address  out  ADDR_W  registered ROM address
rom_q  in  IDX_W  ROM data, ROM_LAT cycles after address
pal_idx  out  IDX_W  rom_q forwarded to external combinational palette
palette_red/green/blue  in  4 each  palette output for pal_idx
red/green/blue  out  4 each  registered pixel colour
opaque  out  1  pixel is sprite-covered and non-transparent
frame_idx  out  $clog2(N_FRAMES)  current animation frame

Behaviour:
- Reset: red/green/blue=0, opaque=0, rom_address=0, frame_idx=0, anim counter=0, latched pos=0, latched enable=0, all pipeline valid bits=0.
- Frame start = cycle with DrawX==0 && DrawY==0. On that cycle latch pos_x, pos_y, enable; position changes mid-frame have no effect (no tearing).
- Animation: at each frame start with anim_run=1, anim counter increments; at ANIM_PERIOD-1 it wraps to 0 and frame_idx advances, N_FRAMES-1 wrapping to 0. anim_run=0 freezes both counters.
- Stage A (cycle 0): dx=DrawX-lx, dy=DrawY-ly in 11-bit signed. hit = enable_l && blank && dx>=0 && dy>=0 && (dx>>SCALE_SHIFT)<SPR_W && (dy>>SCALE_SHIFT)<SPR_H. rom_address <= frame_idx*SPR_W*SPR_H + (dy>>S)*SPR_W + (dx>>S), registered; 0 when !hit. Multiplications are by constants only.
- hit and blank are delayed ROM_LAT cycles alongside the ROM read.
- Output stage (cycle ROM_LAT+1): opaque <= hit_d && rom_q!=TRANSP_IDX; RGB <= palette if opaque, else 0. Total latency DrawX/DrawY -> RGB = ROM_LAT+1 cycles; callers delay hsync/vsync to match.
- Sprite partially off-screen (pos near 639/479): clips naturally; no wrap to left/top edge.
- Reset mid-frame: outputs 0 from next cycle; sprite is hidden until the next frame start with enable=1.
- Frame start with enable=0: entire frame opaque=0.

Optional Feature:
SPRITE_MIRROR_EN: adds input port mirror_x (1 bit), latched at frame start; when latched as 1, texel column = SPR_W-1-(dx>>S). Without the macro, port is absent and no mirroring occurs.

Decomposition:
- Package sprite_pkg: pixel_t struct {r,g,b 4-bit}, screen constants H_ACTIVE=640, V_ACTIVE=480, coordinate width 10.
- Sub-module sprite_addr_gen: stage A (hit test, scaling, frame offset, mirror). Top holds latches, animation counters, delay line and output stage.

Test Plan:
- Reset held 3 cycles mid-line -> RGB=0, opaque=0, frame_idx=0 on every cycle from the first cycle after Reset is sampled.
- pos=(100,50), SCALE_SHIFT=1, DrawX=101,DrawY=53 -> rom_address=1*32+0=32 (frame 0); RGB of rom_q appears ROM_LAT+1 cycles after DrawX/DrawY.
- DrawX=99 or DrawX=164 with pos_x=100 -> opaque=0 (left edge / one past right edge 100+64).
- rom_q=TRANSP_IDX inside sprite -> opaque=0, RGB=0; rom_q=5 -> opaque=1, RGB=palette(5).
- anim_run=1 for 8 frames with ANIM_PERIOD=8 -> frame_idx 0->1; after 32 frames frame_idx wraps to 0; anim_run=0 holds frame_idx.
- pos_x changed 100->200 mid-frame -> remainder of frame still drawn at 100; next frame drawn at 200.
